mul_seq: RTL and testbench
==========================

MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 SHALL have parameter W, default 32, giving the operand width in bits; the bench verifies only W=32.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request to begin a multiplication.
REQ-005 SHALL have port a, input, W bits: multiplicand, unsigned.
REQ-006 SHALL have port b, input, W bits: multiplier, unsigned.
REQ-007 SHALL have port busy, output, 1 bit: high while a multiplication is in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse marking product valid.
REQ-009 SHALL have port p, output, 2W bits: unsigned product a*b.
REQ-010 SHALL have port sig_Z, output, 1 bit: high when p == 0.

Function
REQ-011 SHALL implement a 3-state FSM: IDLE, CALC, DONE.
REQ-012 SHALL, in IDLE with start=1 at a rising edge: latch a into mcand and b into the low register, clear the high accumulator and carry, load the count with W, and enter CALC.
REQ-013 SHALL, in IDLE with start=0, remain in IDLE with registers unchanged.
REQ-014 SHALL, on each CALC cycle, form the (W+1)-bit sum hi + (low[0] ? mcand : 0).
REQ-015 SHALL, on the same edge, shift {carry, hi, low} right by one, taking carry and hi from that sum, then decrement the count.
REQ-016 SHALL perform the CALC addition with the team's 32-bit ripple adder (c_in tied 0, c_out as carry) or an equivalent; the clock period SHALL be at least 200 time units to cover ripple settling.
REQ-017 SHALL leave CALC for DONE on the edge where the count goes from 1 to 0, i.e. after exactly W CALC cycles.
REQ-018 SHALL assert busy=1 throughout all CALC cycles and busy=0 in IDLE and DONE.
REQ-019 SHALL assert done=1 for exactly one cycle in DONE, then return to IDLE unconditionally.
REQ-020 SHALL set latency to W+1 cycles from the start-sampling edge to done high (33 for W=32).
REQ-021 SHALL drive p from the final {hi, low} when DONE is entered.
REQ-022 SHALL hold p and sig_Z stable from DONE until the next accepted start.
REQ-023 SHALL keep p and sig_Z unchanged during CALC (internal registers separate from p).
REQ-024 SHALL register sig_Z together with p, equal to the NOR of all 2W bits of p.
REQ-025 SHALL ignore start asserted in CALC or DONE; no restart and no operand re-latch.
REQ-026 SHALL accept start held high continuously once per pass: IDLE->CALC, giving back-to-back operations every W+2 cycles.
REQ-027 SHALL never overflow: the product of two W-bit unsigned operands fits in 2W bits.
REQ-028 SHALL not affect the current operation if a and b change after acceptance.

Reset
REQ-029 SHALL, while rst_n=0 (asynchronous), set the FSM to IDLE and clear count, mcand, hi, low, carry and p to 0, with busy=0, done=0, sig_Z=1.
REQ-030 SHALL, on rst_n low mid-CALC, abort immediately with no done pulse; the first start after rst_n rises starts a fresh operation.

Verification
REQ-031 SHALL verify zero: a=0, b=32'h12345678, start pulse -> done at cycle 33, p=64'h0, sig_Z=1.
REQ-032 SHALL verify unit: a=1, b=1 -> p=64'h1, sig_Z=0, busy high for exactly 32 cycles.
REQ-033 SHALL verify max carry: a=b=32'hFFFFFFFF -> p=64'hFFFFFFFE00000001.
REQ-034 SHALL verify a start ignored while busy: a=3, b=32'hFFFFFFFF started, then start with a=5, b=5 at cycle 10 -> p=64'h2FFFFFFFD, single done pulse.
REQ-035 SHALL verify reset mid-CALC: rst_n low at cycle 15 -> busy=0, done never pulses, p=0, sig_Z=1; a new start with a=7, b=6 -> p=64'h2A.
REQ-036 SHALL verify back-to-back operation: start held high with a=2, b=3 -> done pulses every 34 cycles with p=64'h6.

Source files
------------

// File: rtl/mul_seq.sv
// Sequential shift-add unsigned multiplier: one partial product per cycle,
// W+2 cycles per operation including the IDLE and DONE states.
module mul_seq_radd #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic [W-1:0] s,
  output logic         c_out
);
  logic c;

  // Bit-serial carry chain written as a loop so it stays one combinational cone.
  always_comb begin
    s = '0;
    c = c_in;
    for (int i = 0; i < W; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
    end
    c_out = c;
  end
endmodule

module mul_seq #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] p,
  output logic           sig_Z
);
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   mcand_q, mcand_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;
  logic [2*W-1:0] p_q, p_d;
  logic           z_q, z_d;

  logic [W-1:0]   addend, sum_lo;
  logic           carry;
  logic           carry_sh;

  assign addend = lo_q[0] ? mcand_q : '0;

  mul_seq_radd #(.W(W)) u_add (
    .a    (hi_q),
    .b    (addend),
    .c_in (1'b0),
    .s    (sum_lo),
    .c_out(carry)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    p_d      = p_q;
    z_d      = z_q;
    carry_sh = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = a;
          lo_d    = b;
          hi_d    = '0;
          cnt_d   = CW'(W);
          state_d = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        // The carry bit falls into hi[W-1]; the vacated carry position is always 0.
        {carry_sh, hi_d, lo_d} = {1'b0, carry, sum_lo, lo_q} >> 1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          p_d     = {hi_d, lo_d};
          z_d     = ~|{hi_d, lo_d};
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      p_q     <= '0;
      z_q     <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      p_q     <= p_d;
      z_q     <= z_d;
    end
  end

  assign p     = p_q;
  assign sig_Z = z_q;
endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq (W=32): latency, busy width, product, zero flag,
// ignored restarts, mid-operation reset and back-to-back throughput.
module tb_mul_seq;
  logic        clk, rst_n, start;
  logic [31:0] a, b;
  logic        busy, done, sig_Z;
  logic [63:0] p;
  int          checks = 0;
  int          failures = 0;

  mul_seq #(.W(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .p    (p),
    .sig_Z(sig_Z)
  );

  initial clk = 1'b0;
  always #100 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Start one operation; n counts falling edges after the start-sampling edge.
  // inj>0 re-asserts start with new operands at that point to prove it is ignored.
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                        input logic [63:0] exp, input int inj);
    int n, bc;
    logic seen;
    logic [63:0] pprev;
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    pprev = p;
    @(posedge clk);
    n = 0; bc = 0; seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (n == 1) start = 1'b0;
      if (n == inj) begin start = 1'b1; a = 32'd5; b = 32'd5; end
      if (inj > 0 && n == inj + 1) start = 1'b0;
      if (n == 16) chk("p_hold_calc", p, pprev);
      if (busy) bc++;
      if (done) seen = 1'b1;
    end
    chk("latency", 64'(n), 64'd33);
    chk("busy_cycles", 64'(bc), 64'd32);
    chk("product", p, exp);
    chk("sig_Z", 64'(sig_Z), 64'(exp == 64'd0));
    @(negedge clk);
    chk("done_single", 64'(done), 64'd0);
    chk("busy_after", 64'(busy), 64'd0);
    chk("p_hold_idle", p, exp);
  endtask

  initial begin
    int n, dn;
    int t[3];
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_p", p, 64'd0);
    chk("rst_z", 64'(sig_Z), 64'd1);
    rst_n = 1'b1;

    run_op(32'd0, 32'h12345678, 64'h0, 0);
    run_op(32'd1, 32'd1, 64'h1, 0);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 0);
    run_op(32'd3, 32'hFFFFFFFF, 64'h2FFFFFFFD, 10);

    // Reset in the middle of an operation.
    @(negedge clk);
    a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_p", p, 64'd0);
    chk("midrst_z", 64'(sig_Z), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("midrst_no_done", 64'(dn), 64'd0);
    run_op(32'd7, 32'd6, 64'h2A, 0);

    // Start held high: one operation per 34 cycles.
    @(negedge clk);
    a = 32'd2; b = 32'd3; start = 1'b1;
    n = 0; dn = 0;
    while (dn < 3 && n < 200) begin
      @(negedge clk);
      n++;
      if (done) begin
        t[dn] = n;
        dn++;
        chk("b2b_p", p, 64'h6);
      end
    end
    start = 1'b0;
    chk("b2b_count", 64'(dn), 64'd3);
    if (dn == 3) begin
      chk("b2b_gap1", 64'(t[1] - t[0]), 64'd34);
      chk("b2b_gap2", 64'(t[2] - t[1]), 64'd34);
    end
    repeat (40) @(negedge clk);
    chk("final_busy", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
